// File: rtl/pusher_scheduler.sv
// Round-robin scheduler that shares one word-to-chunk pusher between NUM_REQ requesters.
// Grants a word, strobes a one-cycle load, then tracks the chunk window with idx/last markers.
module pusher_scheduler #(
  parameter  int BUS_WIDTH  = 32,
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  localparam int CHUNKS     = BUS_WIDTH / DATA_WIDTH,
  localparam int IW         = (CHUNKS  > 1) ? $clog2(CHUNKS)  : 1,
  localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic                         hold_i,
  output logic                         push_load_o,
  output logic [BUS_WIDTH-1:0]         push_data_o,
  output logic                         chunk_valid_o,
  output logic [IW-1:0]                chunk_idx_o,
  output logic                         last_o,
  output logic [GW-1:0]                grant_id_o,
  output logic                         busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PUSH} state_t;

  state_t               r_state;
  logic [IW-1:0]        r_cnt;
  logic [GW-1:0]        r_ptr;
  logic [GW-1:0]        r_gid;
  logic [BUS_WIDTH-1:0] r_data;
  logic                 r_load, r_cvalid, r_last, r_busy;

  logic [NUM_REQ-1:0][BUS_WIDTH-1:0] w_words;
  logic [2*NUM_REQ-1:0]              w_rot;
  logic                              w_found;
  logic [GW-1:0]                     w_sel;
  logic [GW:0]                       w_sum;
  logic [GW-1:0]                     w_next_ptr;
  logic [IW-1:0]                     w_cnt_nxt;
  logic                              w_last_cnt, w_arb, w_grant;

  assign w_words = req_data_i;
  // Rotating the doubled valid vector puts rr_ptr at bit 0, so the lowest set bit wins.
  assign w_rot   = {req_valid_i, req_valid_i} >> r_ptr;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (GW+1)'(i);
        if (w_sum >= (GW+1)'(NUM_REQ)) w_sum = w_sum - (GW+1)'(NUM_REQ);
        w_sel   = w_sum[GW-1:0];
      end
    end
  end

  assign w_next_ptr  = (w_sel == GW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_last_cnt  = (r_cnt == IW'(CHUNKS - 1));
  assign w_arb       = !rst_i && !hold_i &&
                       (r_state == S_IDLE || (r_state == S_PUSH && w_last_cnt));
  assign w_grant     = w_arb && w_found;
  assign req_ready_o = w_grant ? (NUM_REQ'(1) << w_sel) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_gid    <= '0;
      r_data   <= '0;
      r_load   <= 1'b0;
      r_cvalid <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
    end else if (w_grant) begin
      r_state  <= S_LOAD;
      r_data   <= w_words[w_sel];
      r_gid    <= w_sel;
      r_ptr    <= w_next_ptr;
      r_cnt    <= '0;
      r_load   <= 1'b1;
      r_cvalid <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_state  <= S_PUSH;
          r_cnt    <= '0;
          r_load   <= 1'b0;
          r_cvalid <= 1'b1;
          r_last   <= (CHUNKS == 1);
          r_busy   <= 1'b1;
        end
        S_PUSH: begin
          if (w_last_cnt) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_cvalid <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
          end else begin
            r_cnt  <= w_cnt_nxt;
            r_last <= (w_cnt_nxt == IW'(CHUNKS - 1));
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_load   <= 1'b0;
          r_cvalid <= 1'b0;
          r_last   <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign push_load_o   = r_load;
  assign push_data_o   = r_data;
  assign chunk_valid_o = r_cvalid;
  assign chunk_idx_o   = r_cnt;
  assign last_o        = r_last;
  assign grant_id_o    = r_gid;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_pusher_scheduler.sv
// Scoreboard bench: a transaction-level model predicts grants and chunk windows,
// a separate monitor compares every cycle's DUT outputs against those predictions.
module tb_pusher_scheduler;
  localparam int NR = 4;
  localparam int BW = 32;
  localparam int DW = 8;
  localparam int CH = BW / DW;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              hold_i = 1'b0;
  logic [NR-1:0]     req_valid_i = '0;
  logic [NR*BW-1:0]  req_data_i = '0;
  logic [NR-1:0]     req_ready_o;
  logic              push_load_o;
  logic [BW-1:0]     push_data_o;
  logic              chunk_valid_o;
  logic [1:0]        chunk_idx_o;
  logic              last_o;
  logic [1:0]        grant_id_o;
  logic              busy_o;

  pusher_scheduler #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .hold_i(hold_i), .push_load_o(push_load_o),
    .push_data_o(push_data_o), .chunk_valid_o(chunk_valid_o), .chunk_idx_o(chunk_idx_o),
    .last_o(last_o), .grant_id_o(grant_id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  typedef struct {
    int          id;
    logic [BW-1:0] data;
    int          L;      // cycle in which push_load_o is expected
  } txn_t;

  txn_t          txn_q[$];
  logic [NR-1:0] exp_rdy_q[$];

  // Requester word FIFOs; a word leaves its FIFO when the handshake completes.
  logic [BW-1:0] fifo[NR][16];
  int hd[NR];
  int tl[NR];

  int m_ptr   = 0;
  int m_free  = 0;    // earliest cycle that is an arbitration point
  int rst_cyc = -10;

  task automatic push_word(input int k, input logic [BW-1:0] w);
    fifo[k][tl[k] % 16] = w;
    tl[k]++;
  endtask

  function automatic bit q_empty();
    for (int k = 0; k < NR; k++) if (hd[k] != tl[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cycle_drive(input bit rst, input bit hold);
    logic [NR-1:0] v;
    int w;
    @(posedge clk_i); #1;
    rst_i  = rst;
    hold_i = hold;
    for (int k = 0; k < NR; k++) begin
      v[k] = (hd[k] != tl[k]);
      req_data_i[k*BW +: BW] = v[k] ? fifo[k][hd[k] % 16] : BW'($urandom);
    end
    req_valid_i = v;
    if (rst) begin
      exp_rdy_q.push_back('0);
      m_ptr   = 0;
      m_free  = cyc + 1;
      rst_cyc = cyc;
    end else if (cyc >= m_free && !hold && v != '0) begin
      w = -1;
      for (int i = 0; i < NR; i++)
        if (w < 0 && v[(m_ptr + i) % NR]) w = (m_ptr + i) % NR;
      exp_rdy_q.push_back(4'b0001 << w);
      txn_q.push_back('{w, fifo[w][hd[w] % 16], cyc + 1});
      hd[w]++;
      m_ptr  = (w + 1) % NR;
      m_free = cyc + 1 + CH;
    end else begin
      exp_rdy_q.push_back('0);
    end
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while (!(q_empty() && cyc >= m_free) && n < max) begin
      cycle_drive(1'b0, 1'b0);
      n++;
    end
    chk("idle_reached", 64'(n < max), 64'd1);
  endtask

  // Monitor: pops the predicted ready each cycle and the predicted transfer at its load cycle.
  initial begin
    txn_t cur;
    bit   cv;
    int   c;
    logic [NR-1:0] e;
    logic el, ecv, elast, ebusy;
    logic [1:0] eidx, egid;
    logic [BW-1:0] edata;
    cv = 1'b0;
    forever begin
      @(negedge clk_i);
      c = cyc;
      if (exp_rdy_q.size() > 0) begin
        e = exp_rdy_q.pop_front();
        if (c > 1) chk("ready", 64'(req_ready_o), 64'(e));
      end
      if (cv && c > rst_cyc && cur.L <= rst_cyc) cv = 1'b0;
      if (txn_q.size() > 0 && txn_q[0].L == c) begin
        cur = txn_q.pop_front();
        cv  = 1'b1;
      end
      el = 0; ecv = 0; elast = 0; ebusy = 0; eidx = '0;
      egid  = cv ? 2'(cur.id) : 2'd0;
      edata = cv ? cur.data : '0;
      if (cv && c <= cur.L + CH) begin
        ebusy = 1'b1;
        el    = (c == cur.L);
        ecv   = (c > cur.L);
        if (ecv) eidx = 2'(c - cur.L - 1);
        elast = ecv && (c - cur.L - 1 == CH - 1);
      end
      if (c > 1)
        chk("outputs",
            64'({push_load_o, chunk_valid_o, chunk_idx_o, last_o, busy_o, grant_id_o, push_data_o}),
            64'({el, ecv, eidx, elast, ebusy, egid, edata}));
    end
  end

  initial begin
    int k;
    repeat (2) cycle_drive(1'b1, 1'b0);

    // single request from requester 1
    push_word(1, 32'h0ABACDEF);
    run_idle(20);

    // all four continuously valid, pointer back at 0
    cycle_drive(1'b1, 1'b0);
    for (int i = 0; i < NR; i++) push_word(i, {8'(i + 1), 24'hA5C3E1});
    push_word(0, 32'hDEAD0005);
    run_idle(40);

    // wrap-around: grant 2, then 2 and 3 compete with rr_ptr=3
    cycle_drive(1'b1, 1'b0);
    push_word(2, 32'h22220001);
    cycle_drive(1'b0, 1'b0);
    push_word(2, 32'h22220002);
    push_word(3, 32'h33330001);
    run_idle(40);

    // hold raised during PUSH of A while B pending
    push_word(0, 32'hAAAA0001);
    cycle_drive(1'b0, 1'b0);
    cycle_drive(1'b0, 1'b0);
    push_word(1, 32'hBBBB0001);
    repeat (9) cycle_drive(1'b0, 1'b1);
    run_idle(20);

    // reset at chunk_idx 2, then all valid -> requester 0 first
    push_word(0, 32'hC0DE0001);
    repeat (4) cycle_drive(1'b0, 1'b0);
    cycle_drive(1'b1, 1'b0);
    for (int i = NR - 1; i >= 0; i--) push_word(i, {8'hE0 + 8'(i), 24'h123456});
    run_idle(40);

    // back-to-back from one requester
    push_word(2, 32'h61616161);
    push_word(2, 32'h62626262);
    push_word(2, 32'h63636363);
    run_idle(40);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(3) == 0) begin
        k = $urandom_range(NR - 1);
        if (tl[k] - hd[k] < 3) push_word(k, $urandom);
      end
      cycle_drive($urandom_range(149) == 0, $urandom_range(5) == 0);
    end
    run_idle(200);
    repeat (CH + 3) cycle_drive(1'b0, 1'b0);
    chk("drain_req", 64'(q_empty()), 64'd1);
    chk("drain_txn", 64'(txn_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
